jts16b_busarb: RTL and testbench

Bus-grant sequencer that lets the 8751 MCU on System 16B boards take the 68000 bus and run single read/write cycles into mapper-decoded space (work RAM, I/O, mapper registers). It sits between the MCU bridge and the 68000 bus-request pins, driving BRn/BGACKn and a master-side AS/DS/RnW bundle that the top level muxes onto the 68000 address/data path while BGACKn is low. It supplies the `dev_br` source that the 68000 DMA helper currently ties to 0.

---
 rtl/jts16b_busarb.sv | 104 ++++++++++
 tb/tb_jts16b_busarb.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/jts16b_busarb.sv
// jts16b_busarb: lets the MCU borrow the 68000 bus for one read/write cycle via BR/BG/BGACK.
module jts16b_busarb #(
    parameter int TOUT = 31,
    parameter int TW   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        mcu_rq,
    input  logic        mcu_we,
    input  logic [22:0] mcu_addr,
    input  logic [1:0]  mcu_dsn,
    input  logic [15:0] mcu_wdata,
    output logic [15:0] mcu_rdata,
    output logic        mcu_ack,
    output logic        mcu_err,
    output logic        cpu_brn,
    input  logic        cpu_bgn,
    input  logic        cpu_asn,
    output logic        cpu_bgackn,
    output logic        bus_asn,
    output logic [1:0]  bus_dsn,
    output logic        bus_rnw,
    output logic [22:0] bus_addr,
    output logic [15:0] bus_dout,
    input  logic [15:0] bus_din,
    input  logic        bus_dtackn,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, REQ, GRANT, CYC, DONE, REL} state_t;

    state_t         st, nx;
    logic           we_l;
    logic [22:0]    addr_l;
    logic [1:0]     dsn_l;
    logic [15:0]    wdata_l;
    logic [TW-1:0]  cnt, cnt_n;
    logic           dtack, tout, owned;

    assign dtack = !bus_dtackn;
    assign cnt_n = cnt + TW'(1);
    assign tout  = cnt_n == TW'(TOUT);
    assign owned = nx == GRANT || nx == CYC || nx == DONE;

    always_comb begin
        nx = st;
        case (st)
            IDLE:    nx = mcu_rq ? REQ : IDLE;
            REQ:     nx = (!cpu_bgn && cpu_asn) ? GRANT : REQ;
            GRANT:   nx = CYC;
            CYC:     nx = (dtack || tout) ? DONE : CYC;
            DONE:    nx = REL;
            default: nx = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change together with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= IDLE;
            we_l       <= 1'b0;
            addr_l     <= '0;
            dsn_l      <= 2'b11;
            wdata_l    <= '0;
            cnt        <= '0;
            cpu_brn    <= 1'b1;
            cpu_bgackn <= 1'b1;
            bus_asn    <= 1'b1;
            bus_dsn    <= 2'b11;
            bus_rnw    <= 1'b1;
            bus_addr   <= '0;
            bus_dout   <= '0;
            mcu_rdata  <= '0;
            mcu_ack    <= 1'b0;
            mcu_err    <= 1'b0;
            busy       <= 1'b0;
        end else if (cen) begin
            st         <= nx;
            cpu_brn    <= nx != REQ;
            cpu_bgackn <= !owned;
            bus_asn    <= nx != CYC;
            bus_dsn    <= nx == CYC ? dsn_l : 2'b11;
            bus_rnw    <= owned ? !we_l : 1'b1;
            mcu_ack    <= nx == DONE;
            busy       <= nx != IDLE;
            cnt        <= st == CYC ? cnt_n : '0;
            if (st == IDLE && mcu_rq) begin
                we_l    <= mcu_we;
                addr_l  <= mcu_addr;
                dsn_l   <= mcu_dsn;
                wdata_l <= mcu_wdata;
            end
            if (nx == GRANT) begin
                bus_addr <= addr_l;
                bus_dout <= wdata_l;
            end
            // DTACK takes priority over a timeout landing on the same tick
            if (st == CYC && (dtack || tout)) begin
                mcu_err <= !dtack;
                if (dtack && !we_l) mcu_rdata <= bus_din;
            end
        end
    end
endmodule

// File: tb/tb_jts16b_busarb.sv
// tb_jts16b_busarb: directed vectors for the MCU bus-grant sequencer.
module tb_jts16b_busarb;
    logic        clk = 0, rst = 1, cen = 0;
    logic        mcu_rq = 0, mcu_we = 0;
    logic [22:0] mcu_addr = 0;
    logic [1:0]  mcu_dsn = 2'b11;
    logic [15:0] mcu_wdata = 0;
    logic [15:0] mcu_rdata;
    logic        mcu_ack, mcu_err, cpu_brn, cpu_bgackn, bus_asn, bus_rnw, busy;
    logic        cpu_bgn = 1, cpu_asn = 1, bus_dtackn = 1;
    logic [1:0]  bus_dsn;
    logic [22:0] bus_addr;
    logic [15:0] bus_dout, bus_din = 0;
    int          vecs = 0, errs = 0;

    jts16b_busarb #(.TOUT(31), .TW(5)) dut (
        .clk(clk), .rst(rst), .cen(cen),
        .mcu_rq(mcu_rq), .mcu_we(mcu_we), .mcu_addr(mcu_addr), .mcu_dsn(mcu_dsn),
        .mcu_wdata(mcu_wdata), .mcu_rdata(mcu_rdata), .mcu_ack(mcu_ack), .mcu_err(mcu_err),
        .cpu_brn(cpu_brn), .cpu_bgn(cpu_bgn), .cpu_asn(cpu_asn), .cpu_bgackn(cpu_bgackn),
        .bus_asn(bus_asn), .bus_dsn(bus_dsn), .bus_rnw(bus_rnw), .bus_addr(bus_addr),
        .bus_dout(bus_dout), .bus_din(bus_din), .bus_dtackn(bus_dtackn), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cen-qualified edge followed by one edge with cen low
    task automatic tick();
        cen = 1;
        @(posedge clk); #1;
        cen = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        @(posedge clk); #1;
        chk("rst_brn", cpu_brn, 1);
        chk("rst_bgackn", cpu_bgackn, 1);
        chk("rst_asn", bus_asn, 1);
        chk("rst_dsn", bus_dsn, 2'b11);
        chk("rst_rnw", bus_rnw, 1);
        chk("rst_addr", bus_addr, 0);
        chk("rst_dout", bus_dout, 0);
        chk("rst_rdata", mcu_rdata, 0);
        chk("rst_ack", mcu_ack, 0);
        chk("rst_err", mcu_err, 0);
        chk("rst_busy", busy, 0);
        rst = 0;

        // write, grant and DTACK immediate
        mcu_rq = 1; mcu_we = 1; mcu_addr = 23'h20_0000; mcu_wdata = 16'hA55A; mcu_dsn = 2'b00;
        cpu_bgn = 0; cpu_asn = 1; bus_dtackn = 0;
        tick();
        chk("w_req_brn", cpu_brn, 0);
        chk("w_req_bgackn", cpu_bgackn, 1);
        chk("w_req_busy", busy, 1);
        @(posedge clk); #1;
        chk("w_nocen_brn", cpu_brn, 0);
        chk("w_nocen_bgackn", cpu_bgackn, 1);
        tick();
        chk("w_gnt_brn", cpu_brn, 1);
        chk("w_gnt_bgackn", cpu_bgackn, 0);
        chk("w_gnt_asn", bus_asn, 1);
        chk("w_gnt_addr", bus_addr, 23'h20_0000);
        tick();
        chk("w_cyc_asn", bus_asn, 0);
        chk("w_cyc_dsn", bus_dsn, 2'b00);
        chk("w_cyc_dout", bus_dout, 16'hA55A);
        chk("w_cyc_rnw", bus_rnw, 0);
        chk("w_cyc_ack", mcu_ack, 0);
        tick();
        chk("w_done_ack", mcu_ack, 1);
        chk("w_done_err", mcu_err, 0);
        chk("w_done_asn", bus_asn, 1);
        chk("w_done_dsn", bus_dsn, 2'b11);
        chk("w_done_rdata", mcu_rdata, 0);
        mcu_rq = 0;
        tick();
        chk("w_rel_ack", mcu_ack, 0);
        chk("w_rel_bgackn", cpu_bgackn, 1);
        chk("w_rel_brn", cpu_brn, 1);
        chk("w_rel_busy", busy, 1);
        tick();
        chk("w_idle_busy", busy, 0);

        // read, 68k AS held low for 3 cen after BG
        mcu_rq = 1; mcu_we = 0; mcu_addr = 23'h01_2345; mcu_dsn = 2'b00;
        cpu_asn = 0; bus_din = 16'h1234;
        tick();
        chk("r_req_brn", cpu_brn, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("r_wait_bgackn", cpu_bgackn, 1);
            chk("r_wait_brn", cpu_brn, 0);
        end
        cpu_asn = 1;
        tick();
        chk("r_gnt_bgackn", cpu_bgackn, 0);
        chk("r_gnt_rnw", bus_rnw, 1);
        chk("r_gnt_addr", bus_addr, 23'h01_2345);
        tick();
        chk("r_cyc_asn", bus_asn, 0);
        tick();
        chk("r_done_ack", mcu_ack, 1);
        chk("r_done_rdata", mcu_rdata, 16'h1234);
        chk("r_done_err", mcu_err, 0);
        mcu_rq = 0;
        tick(); tick();
        chk("r_idle_busy", busy, 0);

        // timeout: DTACK never arrives
        mcu_rq = 1; bus_dtackn = 1; bus_din = 16'hBEEF;
        tick(); tick(); tick();
        chk("t_cyc_asn", bus_asn, 0);
        mcu_rq = 0;
        for (int i = 1; i < 31; i++) tick();
        chk("t_30_ack", mcu_ack, 0);
        chk("t_30_asn", bus_asn, 0);
        tick();
        chk("t_31_ack", mcu_ack, 1);
        chk("t_31_err", mcu_err, 1);
        chk("t_31_asn", bus_asn, 1);
        chk("t_31_rdata", mcu_rdata, 16'h1234);
        tick(); tick();
        chk("t_idle_bgackn", cpu_bgackn, 1);

        // DTACK on the timeout tick wins
        mcu_rq = 1; bus_din = 16'h5A5A;
        tick(); tick(); tick();
        mcu_rq = 0;
        for (int i = 1; i < 31; i++) tick();
        chk("d_30_ack", mcu_ack, 0);
        bus_dtackn = 0;
        tick();
        chk("d_31_ack", mcu_ack, 1);
        chk("d_31_err", mcu_err, 0);
        chk("d_31_rdata", mcu_rdata, 16'h5A5A);
        tick(); tick();

        // byte strobe on a read
        mcu_rq = 1; mcu_dsn = 2'b10; bus_din = 16'h00C3;
        tick();
        chk("b_req_dsn", bus_dsn, 2'b11);
        tick();
        chk("b_gnt_dsn", bus_dsn, 2'b11);
        tick();
        chk("b_cyc_dsn", bus_dsn, 2'b10);
        tick();
        chk("b_done_dsn", bus_dsn, 2'b11);
        chk("b_done_rdata", mcu_rdata, 16'h00C3);
        mcu_rq = 0;
        tick(); tick();

        // asynchronous reset while in CYC
        mcu_rq = 1; mcu_dsn = 2'b00; bus_dtackn = 1;
        tick(); tick(); tick();
        chk("x_cyc_asn", bus_asn, 0);
        #2 rst = 1;
        #1;
        chk("x_rst_brn", cpu_brn, 1);
        chk("x_rst_bgackn", cpu_bgackn, 1);
        chk("x_rst_asn", bus_asn, 1);
        chk("x_rst_dsn", bus_dsn, 2'b11);
        chk("x_rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 0; bus_dtackn = 0; mcu_we = 1; mcu_wdata = 16'h0F0F;
        tick(); tick(); tick();
        chk("x_new_dout", bus_dout, 16'h0F0F);
        tick();
        chk("x_new_ack", mcu_ack, 1);
        chk("x_new_err", mcu_err, 0);
        mcu_rq = 0;
        tick(); tick();
        chk("x_new_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "time limit");
    end
endmodule
